// File: rtl/mult_accum_pkg.sv
// Shared types and width derivations for the product accumulator.
// ACC_W leaves clog2(N_TERMS) guard bits over a full-scale product so a group can never wrap.
package mult_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int acc_width(input int width, input int n_terms);
        return 2 * width + $clog2(n_terms);
    endfunction

    function automatic int cnt_width(input int n_terms);
        return $clog2(n_terms) + 1;
    endfunction

endpackage

// File: rtl/Multi_unsigned.sv
// Upstream unsigned multiplier feeding mult_accum; purely combinational.
module Multi_unsigned #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P
);

    assign P = A * B;

endmodule

// File: rtl/mult_accum.sv
// Sums a group of up to N_TERMS unsigned products and holds the registered result
// until the downstream consumer accepts it.
module mult_accum
    import mult_accum_pkg::*;
#(
    parameter  int WIDTH   = 9,
    parameter  int N_TERMS = 8,
    parameter  int ACC_W   = acc_width(WIDTH, N_TERMS),
    localparam int CNT_W   = cnt_width(N_TERMS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] p_in,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   sum_out,
    output logic [CNT_W-1:0]   count_out
);

    localparam int PAD_W = ACC_W - 2 * WIDTH;

    function automatic logic [ACC_W-1:0] widen(input logic [2*WIDTH-1:0] p);
        return {{PAD_W{1'b0}}, p};
    endfunction

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W-1:0] sum_next;
    logic [CNT_W-1:0] count_next;
    logic [ACC_W-1:0] sum_term;
    logic [CNT_W-1:0] cnt_inc;

    // The first term of a group loads rather than adds, so a stale accumulator never leaks in.
    assign sum_term = (cnt == '0) ? widen(p_in) : acc + widen(p_in);
    assign cnt_inc  = cnt + CNT_W'(1);

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sum_next   = sum_out;
        count_next = count_out;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last || cnt_inc == CNT_W'(N_TERMS)) begin
                        state_next = HOLD;
                        sum_next   = sum_term;
                        count_next = cnt_inc;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        acc_next = sum_term;
                        cnt_next = cnt_inc;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Result registers are reset too, so no output is ever X after the first reset edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sum_out   <= '0;
            count_out <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            sum_out   <= sum_next;
            count_out <= count_next;
        end
    end

endmodule

// File: tb/tb_mult_accum.sv
// Bench for mult_accum: directed scenarios plus randomized groups fed through Multi_unsigned.
module tb_mult_accum;

    localparam int WIDTH   = 9;
    localparam int N_TERMS = 8;
    localparam int ACC_W   = 21;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p_in;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   sum_out;
    logic [CNT_W-1:0]   count_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    Multi_unsigned #(.WIDTH(WIDTH)) mul (.A(a), .B(b), .P(p_in));

    mult_accum #(.WIDTH(WIDTH), .N_TERMS(N_TERMS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p_in(p_in), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .count_out(count_out)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int av, input int bv, input bit last);
        int n;
        a = WIDTH'(av); b = WIDTH'(bv); in_last = last; in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            tick(); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_wait: in_ready %0b after %0d cycles, required 1", in_ready, n);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hs: in_ready/out_valid %b, required 10", {in_ready, out_valid});
        end
        checks++;
        if (sum_out !== '0 || count_out !== '0) begin
            errors++;
            $display("FAIL reset_data: sum %0d count %0d, required 0 0", sum_out, count_out);
        end
    endtask

    task automatic test_full_group();
        for (int i = 0; i < 8; i++) send(511, 511, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 21'd2088968 || count_out !== 4'd8) begin
            errors++;
            $display("FAIL full_group: valid %b sum %0d count %0d, required 1 2088968 8",
                     out_valid, sum_out, count_out);
        end
        release_out();
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL full_release: in_ready/out_valid %b, required 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_early_last();
        send(2, 3, 1'b0); send(2, 5, 1'b0); send(3, 5, 1'b1);
        tick(); tick();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum_out !== 21'd31 || count_out !== 4'd3) begin
            errors++;
            $display("FAIL early_last: rdy %b valid %b sum %0d count %0d, required 0 1 31 3",
                     in_ready, out_valid, sum_out, count_out);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int bad;
        send(4, 4, 1'b1);
        a = 100; b = 100; in_valid = 1'b1; in_last = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum_out !== 21'd16 || count_out !== 4'd1) bad++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles, required 0 (sum %0d count %0d)",
                     bad, sum_out, count_out);
        end
        release_out();
        send(1, 5, 1'b1);
        #1;
        checks++;
        if (sum_out !== 21'd5 || count_out !== 4'd1) begin
            errors++;
            $display("FAIL backpressure_next: sum %0d count %0d, required 5 1", sum_out, count_out);
        end
        release_out();
    endtask

    task automatic test_single_term();
        send(6, 7, 1'b1);
        #1;
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 21'd42 || count_out !== 4'd1) begin
            errors++;
            $display("FAIL single_term: valid %b sum %0d count %0d, required 1 42 1",
                     out_valid, sum_out, count_out);
        end
        release_out();
    endtask

    task automatic test_last_on_nth();
        int extra;
        for (int i = 0; i < 7; i++) send(1, 1, 1'b0);
        send(1, 1, 1'b1);
        #1;
        checks++;
        if (sum_out !== 21'd8 || count_out !== 4'd8) begin
            errors++;
            $display("FAIL last_on_nth: sum %0d count %0d, required 8 8", sum_out, count_out);
        end
        release_out();
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (out_valid !== 1'b0) extra++;
            tick();
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL last_no_empty: out_valid seen %0d cycles, required 0", extra);
        end
        send(3, 1, 1'b1);
        #1;
        checks++;
        if (sum_out !== 21'd3 || count_out !== 4'd1) begin
            errors++;
            $display("FAIL last_count_clear: sum %0d count %0d, required 3 1", sum_out, count_out);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send(5, 5, 1'b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        send(7, 1, 1'b0); send(9, 1, 1'b1);
        #1;
        checks++;
        if (sum_out !== 21'd16 || count_out !== 4'd2) begin
            errors++;
            $display("FAIL reset_mid: sum %0d count %0d, required 16 2", sum_out, count_out);
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== '0) begin
            errors++;
            $display("FAIL reset_hold: valid %b rdy %b sum %0d, required 0 1 0",
                     out_valid, in_ready, sum_out);
        end
    endtask

    task automatic test_random();
        longint exp_sum[$];
        int     exp_cnt[$];
        longint cur_sum;
        int     cur_n, got, cyc, bad;
        cur_sum = 0; cur_n = 0; got = 0; cyc = 0; bad = 0;
        while (got < 50 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 3) == 0);
            a         = WIDTH'($urandom_range(0, 511));
            b         = WIDTH'($urandom_range(0, 511));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_sum.size() == 0) begin
                    errors++; bad++;
                    $display("FAIL random_spurious: result sum %0d with no group closed", sum_out);
                end else begin
                    if (longint'(sum_out) != exp_sum[0] || int'(count_out) != exp_cnt[0]) begin
                        errors++; bad++;
                        $display("FAIL random_group %0d: sum %0d count %0d, required %0d %0d",
                                 got, sum_out, count_out, exp_sum[0], exp_cnt[0]);
                    end
                    void'(exp_sum.pop_front());
                    void'(exp_cnt.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                cur_sum += longint'(a) * longint'(b);
                cur_n++;
                if (in_last || cur_n == N_TERMS) begin
                    exp_sum.push_back(cur_sum);
                    exp_cnt.push_back(cur_n);
                    cur_sum = 0; cur_n = 0;
                end
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        checks++;
        if (got < 50) begin
            errors++;
            $display("FAIL random_timeout: %0d results in %0d cycles, required 50", got, cyc);
        end
        $display("random groups passed %0d of %0d", got - bad, got);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_early_last();
        test_backpressure();
        test_single_term();
        test_last_on_nth();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
